falcon_scale_ctrl: RTL and testbench

- Sequencer for in-place scaling of a coefficient RAM by 2^(-k) mod q (q = 12289).
- Typical use: inverse-NTT normalisation by n^(-1) = 2^(-logn).
- Reads one coefficient, applies the combinational halve-mod-q datapath k times iteratively (one halving per cycle), then writes the result back to the same address.
- Sits between the NTT top-level controller and the shared coefficient RAM port.

---
 rtl/falcon_scale_ctrl_if.sv | 27 ++
 rtl/falcon_scale_ctrl.sv | 147 ++++++++++++++
 tb/tb_falcon_scale_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/falcon_scale_ctrl_if.sv
// Command and shared coefficient-RAM port bundle for falcon_scale_ctrl.
// The slave view is the sequencer; the master view is the NTT controller plus RAM side.
interface falcon_scale_ctrl_if #(
  parameter int AW = 10,
  parameter int KW = 4
);
  logic          start;
  logic [3:0]    len_log;
  logic [KW-1:0] k;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [13:0]   mem_rd_data;
  logic          mem_wr_en;
  logic [13:0]   mem_wr_data;

  modport slave (
    input  start, len_log, k, mem_rd_data,
    output busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );

  modport master (
    output start, len_log, k, mem_rd_data,
    input  busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/falcon_scale_ctrl.sv
// In-place scaling of a coefficient RAM by 2^(-k) mod Q.
// Each coefficient is read, halved mod Q k times (one step per cycle), then written back.
module falcon_scale_ctrl #(
  parameter int AW = 10,
  parameter int KW = 4,
  parameter int Q  = 12289
) (
  input  logic                 clk,
  input  logic                 rst_n,
  falcon_scale_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_HALVE,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [13:0] HALF = 14'((Q + 1) / 2);

  state_t        state;
  logic [3:0]    len_q;
  logic [KW-1:0] k_q;
  logic [KW-1:0] iter;
  logic [AW-1:0] addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] mem_addr_q;
  logic [13:0]   data_reg;
  logic [13:0]   halved;
  logic [13:0]   wr_data_q;
  logic          busy_q;
  logic          done_q;
  logic          rd_en_q;
  logic          wr_en_q;
  logic [3:0]    len_clamped;

  // x/2 mod Q: odd values become (x-1)/2 + (Q+1)/2, which stays below Q for x < Q.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    halved = {1'b0, data_reg[13:1]};
    if (data_reg[0]) begin
      halved = {1'b0, data_reg[13:1]} + HALF;
    end
  end

  assign len_clamped = (32'(bus.len_log) > AW) ? 4'(AW) : bus.len_log;

  // Shifting past the register width yields zero, so len_q == AW gives an all-ones mask.
  assign last_addr = ~({AW{1'b1}} << len_q);

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd_en   = rd_en_q;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_data = wr_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      k_q        <= '0;
      iter       <= '0;
      addr       <= '0;
      mem_addr_q <= '0;
      data_reg   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            len_q      <= len_clamped;
            k_q        <= bus.k;
            addr       <= '0;
            iter       <= '0;
            mem_addr_q <= '0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state      <= S_RD;
          end
        end

        S_RD: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          data_reg <= bus.mem_rd_data;
          if (k_q == '0) begin
            wr_data_q <= bus.mem_rd_data;
            wr_en_q   <= 1'b1;
            state     <= S_WR;
          end else begin
            iter  <= k_q;
            state <= S_HALVE;
          end
        end

        S_HALVE: begin
          data_reg <= halved;
          iter     <= iter - KW'(1);
          if (iter == KW'(1)) begin
            wr_data_q <= halved;
            wr_en_q   <= 1'b1;
            state     <= S_WR;
          end
        end

        S_WR: begin
          if (addr == last_addr) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            addr       <= addr + AW'(1);
            mem_addr_q <= addr + AW'(1);
            rd_en_q    <= 1'b1;
            state      <= S_RD;
          end
        end

        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falcon_scale_ctrl.sv
// Scoreboard bench for falcon_scale_ctrl: expected RAM writes and done pulses are
// queued per job from a modular-inverse model and popped by an independent monitor.
module tb_falcon_scale_ctrl;
  localparam int AW = 4;
  localparam int KW = 4;
  localparam int Q  = 12289;
  localparam int N  = 1 << AW;

  typedef struct {
    bit is_done;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  falcon_scale_ctrl_if #(.AW(AW), .KW(KW)) bus ();

  falcon_scale_ctrl #(.AW(AW), .KW(KW), .Q(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [13:0] ram [N];
  int          init_vals [N];
  ev_t         exp_q [$];
  int          tests = 0;
  int          fails = 0;

  // RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= ram[bus.mem_addr];
    if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wr_data;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: multiply by the inverse of 2 mod Q, k times.
  function automatic int scale(input int v, input int kk);
    longint r = longint'(v);
    for (int i = 0; i < kk; i++) r = (r * 6145) % Q;
    return int'(r);
  endfunction

  task automatic load_ram();
    for (int i = 0; i < N; i++) ram[i] <= 14'(init_vals[i]);
  endtask

  task automatic push_job(input int upto, input int kk, input bit with_done);
    ev_t e;
    for (int i = 0; i < upto; i++) begin
      e.is_done = 1'b0;
      e.addr    = i;
      e.data    = scale(init_vals[i], kk);
      exp_q.push_back(e);
    end
    if (with_done) begin
      e.is_done = 1'b1;
      e.addr    = 0;
      e.data    = 0;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every write/done the DUT presents against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t e;
      if (bus.mem_rd_en || bus.mem_wr_en)
        check("rd_wr_exclusive", 64'(bus.mem_rd_en & bus.mem_wr_en), 0);
      if (bus.mem_rd_en && !bus.busy)
        check("rd_while_idle", 64'(bus.busy), 1);
      if (bus.mem_wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", 64'(bus.mem_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("wr_kind", 64'(e.is_done), 0);
          check("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
          check("wr_data", 64'(bus.mem_wr_data), 64'(e.data));
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(bus.done), 0);
        end else begin
          e = exp_q.pop_front();
          check("done_kind", 64'(e.is_done), 1);
          check("done_busy", 64'(bus.busy), 1);
        end
      end
    end
  end

  task automatic pulse_start(input int len, input int kk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.len_log = 4'(len);
    bus.k       = KW'(kk);
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic run_job(input int len, input int kk, input bit mid_start);
    int  l;
    int  n;
    int  exp_cyc;
    int  cyc;
    bit  seen;
    l       = (len > AW) ? AW : len;
    n       = 1 << l;
    exp_cyc = n * (3 + kk) + 1;
    @(negedge clk);
    load_ram();
    push_job(n, kk, 1'b1);
    pulse_start(len, kk);
    cyc = 1;
    check("first_rd_en", 64'(bus.mem_rd_en), 1);
    check("first_rd_addr", 64'(bus.mem_addr), 0);
    check("busy_in_job", 64'(bus.busy), 1);
    seen = 1'b0;
    while (cyc <= exp_cyc + 20) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (mid_start && cyc == 3) begin
        bus.start   = 1'b1;
        bus.len_log = 4'd3;
        bus.k       = '0;
      end
      if (mid_start && cyc == 4) bus.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_seen", 64'(seen), 1);
    if (seen) check("done_cycle", 64'(cyc), 64'(exp_cyc));
    @(negedge clk);
    check("busy_after_done", 64'(bus.busy), 0);
    if (mid_start) repeat (12) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    64'(bus.busy), 0);
    check({tag, "_done"},    64'(bus.done), 0);
    check({tag, "_rd_en"},   64'(bus.mem_rd_en), 0);
    check({tag, "_wr_en"},   64'(bus.mem_wr_en), 0);
    check({tag, "_addr"},    64'(bus.mem_addr), 0);
    check({tag, "_wr_data"}, 64'(bus.mem_wr_data), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    bus.start   = 1'b0;
    bus.len_log = '0;
    bus.k       = '0;
    for (int i = 0; i < N; i++) init_vals[i] = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single coefficient, one halving: 3 -> 6146.
    init_vals[0] = 3;
    run_job(0, 1, 1'b0);

    // Four coefficients, ten halvings each.
    init_vals[0] = 1; init_vals[1] = 2; init_vals[2] = 12288; init_vals[3] = 0;
    run_job(2, 10, 1'b0);

    // k = 0 passes values through unchanged at 3 cycles per coefficient.
    for (int i = 0; i < 8; i++) init_vals[i] = i * 1000;
    run_job(3, 0, 1'b0);

    // A second start mid-job must be ignored.
    init_vals[0] = 4; init_vals[1] = 12288;
    run_job(1, 2, 1'b1);

    // Reset during the halving of address 2 aborts the job.
    for (int i = 0; i < N; i++) init_vals[i] = int'($urandom_range(0, Q - 1));
    @(negedge clk);
    load_ram();
    push_job(2, 5, 1'b0);
    pulse_start(4, 5);
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.mem_rd_en && bus.mem_addr == AW'(2)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("abort_rd_addr2_seen", 64'(found), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (3) @(negedge clk);
    check("abort_no_write_addr2", 64'(ram[2]), 64'(init_vals[2]));
    check("abort_queue_drained", 64'(exp_q.size()), 0);
    exp_q.delete();
    rst_n = 1'b1;
    run_job(2, 3, 1'b0);

    // len_log above AW clamps to the full 2^AW coefficients.
    for (int i = 0; i < N; i++) init_vals[i] = int'($urandom_range(0, Q - 1));
    run_job(15, 2, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      int len;
      int kk;
      len = (j == 5) ? 9 : int'($urandom_range(0, AW));
      kk  = int'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) init_vals[i] = int'($urandom_range(0, Q - 1));
      run_job(len, kk, 1'b0);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
